// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if: handshake bundle for conv2d_stream.
//   coef_*   : coefficient stream, row-major, valid/ready
//   pix_*    : pixel stream, raster order, valid/ready
//   out_*    : result stream, out_last marks the final result of a frame
//   kernel_loaded : all KERNEL_SIZE^2 coefficients present
// Modports: slave = the convolution block, master = the traffic source/sink.
interface conv2d_stream_if #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned COEF_W      = 8,
  parameter int unsigned KERNEL_SIZE = 3
);
  localparam int unsigned ACC_W = DATA_W + COEF_W + $clog2(KERNEL_SIZE * KERNEL_SIZE) + 1;

  logic                     coef_valid;
  logic [COEF_W-1:0]        coef_data;
  logic                     coef_ready;
  logic                     pix_valid;
  logic [DATA_W-1:0]        pix_data;
  logic                     pix_ready;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;
  logic                     out_ready;
  logic                     kernel_loaded;

  modport slave (
    input  coef_valid, coef_data, pix_valid, pix_data, out_ready,
    output coef_ready, pix_ready, out_valid, out_data, out_last, kernel_loaded
  );

  modport master (
    output coef_valid, coef_data, pix_valid, pix_data, out_ready,
    input  coef_ready, pix_ready, out_valid, out_data, out_last, kernel_loaded
  );
endinterface

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming K x K 2-D convolution, "valid" mode (no padding).
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus_io  : conv2d_stream_if.slave (coefficient, pixel and result streams)
// Optional feature: define CONV2D_RELU_EN to clamp negative sums to zero.
module conv2d_stream #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned COEF_W      = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IMG_WIDTH   = 16,
  parameter int unsigned IMG_HEIGHT  = 16
) (
  input logic            clk,
  input logic            reset_n,
  conv2d_stream_if.slave bus_io
);
  localparam int unsigned K       = KERNEL_SIZE;
  localparam int unsigned NCoef   = K * K;
  localparam int unsigned ACC_W   = DATA_W + COEF_W + $clog2(NCoef) + 1;
  localparam int unsigned CntW    = $clog2(NCoef);
  localparam int unsigned ColW    = $clog2(IMG_WIDTH);
  localparam int unsigned RowW    = $clog2(IMG_HEIGHT);
  localparam logic [CntW-1:0] CntLast  = CntW'(NCoef - 1);
  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_HEIGHT - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(K - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(K - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          cnt_q;
  logic signed [COEF_W-1:0] coef_q [NCoef];
  logic                     loaded_q;
  logic                     awake_q;  // low during reset, high from the first edge after it

  logic [RowW-1:0]          row_q;
  logic [ColW-1:0]          col_q;
  logic                     out_valid_q;
  logic signed [ACC_W-1:0]  out_data_q;
  logic                     out_last_q;

  logic [DATA_W-1:0]        lb_q  [K-1][IMG_WIDTH];
  logic [DATA_W-1:0]        win_q [K][K];
  logic [DATA_W-1:0]        win_d [K][K];

  logic                     coef_ready;
  logic                     pix_ready;
  logic                     coef_hs;
  logic                     pix_hs;
  logic                     produce;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  res;

  // In RUN a new kernel is only taken at a clean frame boundary.
  assign coef_ready = awake_q &&
                      ((state_q != StRun) || (row_q == '0 && col_q == '0 && !out_valid_q));
  assign pix_ready  = (state_q == StRun) && (!out_valid_q || bus_io.out_ready);
  assign coef_hs    = bus_io.coef_valid && coef_ready;
  assign pix_hs     = bus_io.pix_valid && pix_ready;
  assign produce    = pix_hs && (row_q >= RowFirst) && (col_q >= ColFirst);

  assign bus_io.coef_ready    = coef_ready;
  assign bus_io.pix_ready     = pix_ready;
  assign bus_io.out_valid     = out_valid_q;
  assign bus_io.out_data      = out_data_q;
  assign bus_io.out_last      = out_last_q;
  assign bus_io.kernel_loaded = loaded_q;

  // Kernel load FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      awake_q  <= 1'b0;
      for (int unsigned n = 0; n < NCoef; n++) coef_q[n] <= '0;
    end else begin
      awake_q <= 1'b1;
      if (coef_hs) begin
        coef_q[cnt_q] <= bus_io.coef_data;
        unique case (state_q)
          StIdle, StLoad: begin
            if (cnt_q == CntLast) begin
              state_q  <= StRun;
              cnt_q    <= '0;
              loaded_q <= 1'b1;
            end else begin
              state_q <= StLoad;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          StRun: begin
            // cnt_q is 0 in RUN, so this coefficient lands in slot 0.
            state_q  <= StLoad;
            cnt_q    <= CntW'(1);
            loaded_q <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Window after shifting in the current pixel; the result is computed from it.
  always_comb begin
    win_d = win_q;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j + 1 < K; j++) win_d[i][j] = win_q[i][j+1];
    end
    win_d[K-1][K-1] = bus_io.pix_data;
    for (int unsigned r = 0; r + 1 < K; r++) win_d[K-2-r][K-1] = lb_q[r][IMG_WIDTH-1];
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        sum = sum + ($signed(ACC_W'(win_d[i][j])) * ACC_W'(coef_q[i*K+j]));
      end
    end
`ifdef CONV2D_RELU_EN
    res = sum[ACC_W-1] ? '0 : sum;
`else
    res = sum;
`endif
  end

  // Line buffers form one continuous delay line of (K-1) rows; no reset needed
  // because results are gated by row/col, never by buffer contents.
  always_ff @(posedge clk) begin
    if (pix_hs) begin
      win_q       <= win_d;
      lb_q[0][0]  <= bus_io.pix_data;
      for (int unsigned r = 1; r + 1 < K; r++) lb_q[r][0] <= lb_q[r-1][IMG_WIDTH-1];
      for (int unsigned r = 0; r + 1 < K; r++) begin
        for (int unsigned c = 1; c < IMG_WIDTH; c++) lb_q[r][c] <= lb_q[r][c-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (pix_hs) begin
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      // A new result wins over a simultaneous consume.
      if (produce) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
        out_last_q  <= (row_q == RowLast) && (col_q == ColLast);
      end else if (bus_io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int K     = 3;
  localparam int ACC_W = 8 + 8 + $clog2(K * K) + 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  conv2d_stream_if #(.DATA_W(8), .COEF_W(8), .KERNEL_SIZE(K)) bus ();

  conv2d_stream #(
    .DATA_W     (8),
    .COEF_W     (8),
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   img  [W*H];
  int   kern [K*K];

  function automatic exp_t model(input int r, input int c);
    int   s;
    exp_t e;
    s = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        s += img[(r - K + 1 + i) * W + (c - K + 1 + j)] * kern[i*K+j];
      end
    end
`ifdef CONV2D_RELU_EN
    if (s < 0) s = 0;
`endif
    e.data = ACC_W'(s);
    e.last = (r == H - 1) && (c == W - 1);
    return e;
  endfunction

  // Scoreboard: pop and compare every consumed result.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_result data=%0d required none", bus.out_data);
      end else begin
        mon_e = sb.pop_front();
        if (bus.out_data !== $signed(mon_e.data) || bus.out_last !== mon_e.last)
          $display("FAIL result data=%0d last=%0b required data=%0d last=%0b",
                   bus.out_data, bus.out_last, $signed(mon_e.data), mon_e.last);
        else passes++;
      end
    end
  end

  task automatic send_coef(input int v);
    int n = 0;
    bus.coef_valid = 1'b1;
    bus.coef_data  = 8'(v);
    @(negedge clk);
    while (!bus.coef_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.coef_ready) begin
      checks++;
      $display("FAIL coef_handshake_timeout coef_ready=0 required 1");
    end
    @(posedge clk); #1;
    bus.coef_valid = 1'b0;
  endtask

  task automatic send_pix(input int idx);
    int   n = 0;
    int   r = idx / W;
    int   c = idx % W;
    logic prod;
    prod = (r >= K - 1) && (c >= K - 1);
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'(img[idx]);
    if (prod) sb.push_back(model(r, c));
    @(negedge clk);
    while (!bus.pix_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.pix_ready) begin
      checks++;
      $display("FAIL pix_handshake_timeout idx=%0d pix_ready=0 required 1", idx);
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    // With out_ready high, out_valid mirrors whether this pixel completed a window.
    if (bus.out_ready) begin
      checks++;
      if (bus.out_valid !== prod)
        $display("FAIL out_valid_latency idx=%0d out_valid=%0b required %0b",
                 idx, bus.out_valid, prod);
      else passes++;
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < W * H; i++) send_pix(i);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0)
      $display("FAIL drain pending=%0d out_valid=%0b required 0 0", sb.size(), bus.out_valid);
    else passes++;
  endtask

  task automatic load_kernel();
    for (int n = 0; n < K * K; n++) begin
      send_coef(kern[n]);
      checks++;
      if (bus.kernel_loaded !== (n == K * K - 1))
        $display("FAIL kernel_loaded after_coef=%0d got=%0b required %0b",
                 n, bus.kernel_loaded, (n == K * K - 1));
      else passes++;
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < W * H; i++) img[i] = i;
  endtask

  task automatic set_kern_const(input int v);
    for (int i = 0; i < K * K; i++) kern[i] = v;
  endtask

  task automatic set_kern_identity();
    set_kern_const(0);
    kern[(K * K) / 2] = 1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.kernel_loaded, bus.pix_ready,
         bus.coef_ready} !== '0)
      $display("FAIL reset_outputs ov=%0b od=%0d ol=%0b kl=%0b pr=%0b cr=%0b required all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.kernel_loaded, bus.pix_ready,
               bus.coef_ready);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.coef_ready !== 1'b1 || bus.pix_ready !== 1'b0)
      $display("FAIL post_reset_ready coef_ready=%0b pix_ready=%0b required 1 0",
               bus.coef_ready, bus.pix_ready);
    else passes++;
  endtask

  task automatic test_identity();
    set_kern_identity();
    set_ramp();
    load_kernel();
    send_frame();
    wait_drain();
  endtask

  task automatic test_ones();
    set_kern_const(1);
    load_kernel();
    send_frame();
    wait_drain();
  endtask

  task automatic test_negative();
    set_kern_const(-1);
    load_kernel();
    send_frame();
    wait_drain();
  endtask

  task automatic test_back_to_back_stall();
    set_kern_const(1);
    load_kernel();
    for (int i = 0; i <= 10; i++) send_pix(i);
    bus.out_ready = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'(img[11]);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (bus.pix_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== $signed(sb[0].data))
        $display("FAIL stall_hold pix_ready=%0b out_valid=%0b out_data=%0d required 0 1 %0d",
                 bus.pix_ready, bus.out_valid, bus.out_data, $signed(sb[0].data));
      else passes++;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 11; i < W * H; i++) send_pix(i);
    wait_drain();
  endtask

  task automatic test_midframe_coef();
    for (int i = 0; i < 6; i++) send_pix(i);
    bus.coef_valid = 1'b1;
    bus.coef_data  = 8'd7;
    @(negedge clk);
    checks++;
    if (bus.coef_ready !== 1'b0 || bus.kernel_loaded !== 1'b1)
      $display("FAIL midframe_coef coef_ready=%0b kernel_loaded=%0b required 0 1",
               bus.coef_ready, bus.kernel_loaded);
    else passes++;
    @(posedge clk); #1;
    bus.coef_valid = 1'b0;
    for (int i = 6; i < W * H; i++) send_pix(i);
    wait_drain();
    checks++;
    if (bus.coef_ready !== 1'b1)
      $display("FAIL boundary_coef_ready coef_ready=%0b required 1", bus.coef_ready);
    else passes++;
    set_kern_identity();
    load_kernel();
    send_frame();
    wait_drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i <= 7; i++) send_pix(i);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.kernel_loaded, bus.pix_ready,
         bus.coef_ready} !== '0)
      $display("FAIL async_reset_outputs ov=%0b od=%0d ol=%0b kl=%0b pr=%0b cr=%0b required all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.kernel_loaded, bus.pix_ready,
               bus.coef_ready);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.kernel_loaded !== 1'b0 || bus.pix_ready !== 1'b0 || bus.coef_ready !== 1'b1)
      $display("FAIL reset_needs_reload kl=%0b pr=%0b cr=%0b required 0 0 1",
               bus.kernel_loaded, bus.pix_ready, bus.coef_ready);
    else passes++;
    set_kern_identity();
    load_kernel();
    send_frame();
    wait_drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < K * K; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < W * H; i++) img[i] = int'($urandom_range(0, 255));
    load_kernel();
    send_frame();
    wait_drain();
  endtask

  initial begin
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_identity();
    test_ones();
    test_negative();
    test_back_to_back_stall();
    test_midframe_coef();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end
endmodule
